// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline stage with stall, flush and optional skid register
// Define PIPE_STAGE_SKID_EN for two-entry (main + skid) buffering; default build is a single register.
module pipe_stage #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy
);
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  assign out_valid   = r_main_valid & ~stall;
  assign out_data    = r_main_data;
  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = out_valid & out_ready;
  assign w_main_load = w_in_fire & (~r_main_valid | (w_out_fire & ~w_skid_valid));
`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  assign w_skid_valid = r_skid_valid;
  assign w_skid_data  = r_skid_data;
  assign in_ready     = ~r_skid_valid & ~stall & ~flush;
  assign occupancy    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
  // skid catches an accepted entry while main is full and not draining; empties when main drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
    end else if (w_out_fire) begin
      r_skid_valid <= 1'b0;
    end else if (w_in_fire && r_main_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end
`else
  assign w_skid_valid = 1'b0;
  assign w_skid_data  = RESET_VAL;
  assign in_ready     = (~r_main_valid | out_ready) & ~stall & ~flush;
  assign occupancy    = {1'b0, r_main_valid};
`endif
  // main register: refilled from skid first, else from input; empties when drained with nothing behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RESET_VAL;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_main_data  <= RESET_VAL;
    end else if (w_out_fire && w_skid_valid) begin
      r_main_data  <= w_skid_data;
    end else if (w_main_load) begin
      r_main_valid <= 1'b1;
      r_main_data  <= in_data;
    end else if (w_out_fire) begin
      r_main_valid <= 1'b0;
    end
  end
endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried by the stage.
REQ-002 Parameter RESET_VAL, default 0, value loaded into out_data on reset and flush.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low: asserting rst low clears the stage immediately, independent of clk.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  stage accepts in_data this cycle.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 out_valid  output  1  out_data holds a live entry.
REQ-009 out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 out_data  output  DATA_W  head-of-stage payload.
REQ-011 stall  input  1  freeze: no transfer in or out; contents held.
REQ-012 flush  input  1  discard all held entries.
REQ-013 occupancy  output  2  number of live entries (0..2).

Function
REQ-014 The input transfer SHALL occur only when in_valid and in_ready are both high at a rising clk edge; the output transfer SHALL occur only when out_valid and out_ready are both high.
REQ-015 Storage SHALL be a main register (drives out_data) plus one skid register; entries leave in arrival order.
REQ-016 out_valid SHALL equal main_valid AND NOT stall.
REQ-017 With skid: in_ready SHALL equal NOT skid_valid AND NOT stall AND NOT flush; in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 Input transfer with main empty, or with main firing out the same cycle and skid empty, SHALL load main (one-cycle latency, in to out).
REQ-019 Input transfer with main full and not firing out SHALL load skid.
REQ-020 Output transfer with skid full SHALL move skid into main and clear skid in the same edge.
REQ-021 Simultaneous input and output transfer with occupancy 1 SHALL leave occupancy 1 with main holding the new entry.
REQ-022 Full (occupancy 2): in_ready low; back-to-back streaming with out_ready held high SHALL sustain one transfer per cycle.
REQ-023 Stall high SHALL hold both registers, valids and occupancy unchanged.
REQ-024 Flush SHALL have priority over stall and both transfers: next edge clears both valids, occupancy to 0, out_data to RESET_VAL; an in_data offered in a flush cycle is dropped.
REQ-025 Registers not loaded in a cycle SHALL keep their data; an empty stage is a bubble via out_valid low, not by data zeroing.

Reset
REQ-026 While rst is low: out_valid 0, skid valid 0, occupancy 0, out_data RESET_VAL, skid data RESET_VAL; in_ready follows REQ-017/REQ-030 from cleared state.
REQ-027 rst asserted mid-transfer SHALL abort it; no entry survives; first transfer possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN SHALL select the buffering mode.
REQ-029 Defined: two-entry behaviour per REQ-015..REQ-022.
REQ-030 Undefined: no skid register; in_ready = (NOT main_valid OR out_ready) AND NOT stall AND NOT flush; occupancy never exceeds 1; all other rules unchanged.

Verification
REQ-031 Reset: rst low mid-stream with RESET_VAL=0 -> out_valid 0, occupancy 0, out_data 0 asynchronously, before the next clk edge.
REQ-032 Stream: in_valid high for 8 cycles with data 1..8, out_ready high -> out_data 1..8 on consecutive cycles, one cycle latency, no gaps.
REQ-033 Backpressure (SKID_EN): push A,B with out_ready low -> occupancy 2, in_ready low; raise out_ready -> A then B on consecutive cycles.
REQ-034 Stall: occupancy 1 holding 0x55, stall high 3 cycles with out_ready high -> out_valid 0, data 0x55 held; stall low -> 0x55 delivered.
REQ-035 Flush: occupancy 2 plus in_valid with 0x77, stall high, flush high -> next edge occupancy 0, out_data RESET_VAL, 0x77 never appears.
REQ-036 No-skid build: out_ready low, full stage -> in_ready low; out_ready high with in_valid -> simultaneous in/out, occupancy stays 1.
